popcount_act_unit: RTL

//  XNOR-popcount accumulator + sign activation for one binarized neuron. Consumes
//  the 1-bit mismatch stream (weight XOR input) produced by compute_module and

---
 rtl/popcount_act_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/popcount_act_unit.sv
// XNOR-popcount accumulator with sign activation for one binarized neuron.
// Define POPCNT_BIAS_EN to add a signed bias input, latched when a neuron starts.
module popcount_act_unit #(
    parameter int FAN_IN     = 784,
    parameter int ACC_WIDTH  = 12,
    parameter int BIAS_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic                 in_bit,
`ifdef POPCNT_BIAS_EN
    input  logic [BIAS_WIDTH-1:0] bias,
`endif
    output logic                 busy,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 act_out,
    output logic                 out_valid,
    output logic                 overflow
);

    localparam int BW = $clog2(FAN_IN + 1);
    localparam int SW = ((ACC_WIDTH > BIAS_WIDTH) ? ACC_WIDTH : BIAS_WIDTH) + 3;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(FAN_IN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [ACC_WIDTH-1:0]  match_cnt_q, match_cnt_d;
    logic                  overflow_q, overflow_d;
    logic [ACC_WIDTH-1:0]  acc_out_q, acc_out_d;
    logic                  act_out_q, act_out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic [BIAS_WIDTH-1:0] bias_q;

`ifdef POPCNT_BIAS_EN
    logic [BIAS_WIDTH-1:0] bias_d;
`else
    assign bias_q = '0;
`endif

    // Activation sign: 2*match - FAN_IN + bias, in a width that cannot overflow
    logic signed [SW-1:0] two_m, fan, b_ext, act_sum;

    always_comb begin
        two_m   = SW'({match_cnt_q, 1'b0});
        fan     = SW'(FAN_IN);
        b_ext   = SW'($signed(bias_q));
        act_sum = two_m - fan + b_ext;
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        match_cnt_d = match_cnt_q;
        overflow_d  = overflow_q;
        acc_out_d   = acc_out_q;
        act_out_d   = act_out_q;
        out_valid_d = 1'b0;
`ifdef POPCNT_BIAS_EN
        bias_d      = bias_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_ACCUM;
                    beat_cnt_d  = '0;
                    match_cnt_d = '0;
                    overflow_d  = 1'b0;
`ifdef POPCNT_BIAS_EN
                    bias_d      = bias;
`endif
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                    if (!in_bit) begin
                        if (match_cnt_q == ACC_MAX) overflow_d = 1'b1;
                        else match_cnt_d = match_cnt_q + ACC_WIDTH'(1);
                    end
                    if (beat_cnt_q == LAST_BEAT) state_d = S_DONE;
                end
            end
            S_DONE: begin
                acc_out_d   = match_cnt_q;
                act_out_d   = ~act_sum[SW-1];
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_cnt_q  <= '0;
            match_cnt_q <= '0;
            overflow_q  <= 1'b0;
            acc_out_q   <= '0;
            act_out_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            match_cnt_q <= match_cnt_d;
            overflow_q  <= overflow_d;
            acc_out_q   <= acc_out_d;
            act_out_q   <= act_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef POPCNT_BIAS_EN
    always_ff @(posedge clk) begin
        if (rst) bias_q <= '0;
        else bias_q <= bias_d;
    end
`endif

    assign busy      = busy_q;
    assign acc_out   = acc_out_q;
    assign act_out   = act_out_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

endmodule
